dice_roll_gen: RTL and testbench

//  Upstream stage of the snake-and-ladder board engine. Generates fair dice values (1..6) from an

---
 rtl/dice_roll_gen.sv | 149 ++++++++++++++
 tb/tb_dice_roll_gen.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dice_roll_gen.sv
// dice_roll_gen
//   Upstream stage of the snake-and-ladder board engine. Draws fair dice
//   faces (1..6) from a seedable 16-bit Fibonacci LFSR. It also tracks which
//   player owns the next roll, and offers each roll to the board stage on a
//   valid/ready handshake.
//
// Ports
//   clk          in   1       system clock, all state on rising edge
//   reset        in   1       asynchronous, active-low reset
//   start_game   in   1       game enable; low aborts to IDLE except in HOLD
//   seed_load    in   1       load seed_in into the LFSR (IDLE only)
//   seed_in      in   LFSR_W  seed value (zero is replaced by SEED)
//   roll_req     in   1       board stage requests the next roll
//   game_over    in   1       board stage reports a winner
//   roll_valid   out  1       dice_roll/player_turn are valid
//   roll_ready   in   1       board stage accepts the roll
//   dice_roll    out  3       face value 1..6, 0 while roll_valid is low
//   player_turn  out  1       owner of the roll; 1 = P1, 0 = P2
//   roll_count   out  8       accepted rolls since reset, saturating at 255
module dice_roll_gen #(
  parameter int                LFSR_W  = 16,
  parameter logic [LFSR_W-1:0] SEED    = 16'hACE1,
  parameter int                MAX_REJ = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_game,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed_in,
  input  logic              roll_req,
  input  logic              game_over,
  output logic              roll_valid,
  input  logic              roll_ready,
  output logic [2:0]        dice_roll,
  output logic              player_turn,
  output logic [7:0]        roll_count
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DRAW = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam int REJ_W = $clog2(MAX_REJ + 1);
  localparam logic [REJ_W-1:0] REJ_LAST = REJ_W'(MAX_REJ - 1);

  logic [1:0]        state, state_nxt;
  logic [LFSR_W-1:0] lfsr, lfsr_nxt, lfsr_shift;
  logic [REJ_W-1:0]  rej_cnt, rej_nxt;
  logic [2:0]        dice_nxt;
  logic              turn_nxt;
  logic [7:0]        count_nxt;
  logic [2:0]        face;
  logic              handshake;

  // The taps are fixed for a 16-bit register.
  assign lfsr_shift = {lfsr[LFSR_W-2:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  assign face       = lfsr[2:0];
  assign handshake  = roll_valid & roll_ready;

  // Next-state logic. The LFSR advances on every cycle spent in DRAW, even
  // when start_game drops or game_over arrives in that cycle. dice_roll is
  // cleared whenever the FSM is outside HOLD, so it reads 0 while roll_valid
  // is low.
  always_comb begin
    state_nxt = state;
    lfsr_nxt  = lfsr;
    rej_nxt   = rej_cnt;
    dice_nxt  = dice_roll;
    turn_nxt  = player_turn;
    count_nxt = roll_count;
    case (state)
      IDLE: begin
        dice_nxt = 3'd0;
        if (seed_load) begin
          lfsr_nxt = (seed_in == '0) ? SEED : seed_in;
        end
        if (game_over) begin
          state_nxt = DONE;
        end else if (!seed_load && start_game && roll_req) begin
          state_nxt = DRAW;
        end
      end
      DRAW: begin
        lfsr_nxt = lfsr_shift;
        if (!start_game) begin
          rej_nxt   = '0;
          state_nxt = IDLE;
        end else if (game_over) begin
          rej_nxt   = '0;
          state_nxt = DONE;
        end else if (face != 3'd0 && face != 3'd7) begin
          dice_nxt  = face;
          rej_nxt   = '0;
          state_nxt = HOLD;
        end else if (rej_cnt == REJ_LAST) begin
          // Out of retries: 0 and 7 fold onto 1 and 2 so the roll stays bounded.
          dice_nxt  = (face == 3'd0) ? 3'd1 : 3'd2;
          rej_nxt   = '0;
          state_nxt = HOLD;
        end else begin
          rej_nxt = rej_cnt + 1'b1;
        end
      end
      HOLD: begin
        // Roll stays offered regardless of start_game until accepted.
        if (handshake) begin
          turn_nxt  = ~player_turn;
          count_nxt = (roll_count == 8'hFF) ? roll_count : roll_count + 8'd1;
          dice_nxt  = 3'd0;
          state_nxt = game_over ? DONE : IDLE;
        end
      end
      DONE: begin
        dice_nxt = 3'd0;
        if (!start_game) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        dice_nxt  = 3'd0;
        state_nxt = IDLE;
      end
    endcase
  end

  // State registers. roll_valid is registered from the next-state decode, so
  // it is high exactly while the FSM sits in HOLD.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      lfsr        <= SEED;
      rej_cnt     <= '0;
      roll_valid  <= 1'b0;
      dice_roll   <= 3'd0;
      player_turn <= 1'b1;
      roll_count  <= 8'd0;
    end else begin
      state       <= state_nxt;
      lfsr        <= lfsr_nxt;
      rej_cnt     <= rej_nxt;
      roll_valid  <= (state_nxt == HOLD);
      dice_roll   <= dice_nxt;
      player_turn <= turn_nxt;
      roll_count  <= count_nxt;
    end
  end

endmodule

// File: tb/tb_dice_roll_gen.sv
// tb_dice_roll_gen
//   Scoreboard bench for dice_roll_gen. When a roll is requested, the bench
//   predicts its face, its owner and its latency from its own LFSR model. It
//   queues that prediction and checks it when roll_valid rises.
module tb_dice_roll_gen;

  localparam int MAX_REJ = 4;
  localparam logic [15:0] SEED = 16'hACE1;

  logic        clk;
  logic        reset;
  logic        start_game;
  logic        seed_load;
  logic [15:0] seed_in;
  logic        roll_req;
  logic        game_over;
  logic        roll_valid;
  logic        roll_ready;
  logic [2:0]  dice_roll;
  logic        player_turn;
  logic [7:0]  roll_count;

  typedef struct {
    logic [2:0] dice;
    logic       player;
    int         lat;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] model_lfsr;
  logic        model_player;
  logic [7:0]  model_count;
  int          tests_run;
  int          tests_failed;

  dice_roll_gen #(.LFSR_W(16), .SEED(SEED), .MAX_REJ(MAX_REJ)) dut (
    .clk         (clk),
    .reset       (reset),
    .start_game  (start_game),
    .seed_load   (seed_load),
    .seed_in     (seed_in),
    .roll_req    (roll_req),
    .game_over   (game_over),
    .roll_valid  (roll_valid),
    .roll_ready  (roll_ready),
    .dice_roll   (dice_roll),
    .player_turn (player_turn),
    .roll_count  (roll_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference draw: one LFSR step per DRAW cycle, with the fallback mapping
  // on the last permitted attempt.
  function automatic void model_draw(inout logic [15:0] l, output logic [2:0] f, output int draws);
    logic [2:0] r;
    f     = 3'd0;
    draws = 0;
    for (int i = 0; i < MAX_REJ; i++) begin
      r = l[2:0];
      l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
      draws++;
      if (r >= 3'd1 && r <= 3'd6) begin
        f = r;
        return;
      end
      if (i == MAX_REJ - 1) begin
        f = (r == 3'd0) ? 3'd1 : 3'd2;
        return;
      end
    end
  endfunction

  // Requests one roll from IDLE, checks the offered roll against the
  // scoreboard, stalls for 'stall' cycles, then accepts with game_over=go.
  task automatic run_roll(input int stall, input logic go, output logic [2:0] got_dice, output int got_lat);
    exp_t e;
    exp_t p;
    int   edges;
    model_draw(model_lfsr, e.dice, e.lat);
    e.player = model_player;
    sb.push_back(e);
    got_dice = 3'd0;
    roll_req = 1'b1;
    @(negedge clk);
    roll_req = 1'b0;
    edges = 1;
    while (!roll_valid && edges < 20) begin
      @(negedge clk);
      edges++;
    end
    got_lat = edges - 1;
    tests_run++;
    if (!roll_valid) begin
      tests_failed++;
      $display("[TB] FAIL roll_valid_timeout: roll_valid=%0b after %0d edges, required 1", roll_valid, edges);
      void'(sb.pop_front());
      return;
    end
    tests_run++;
    if (sb.size() == 0) begin
      tests_failed++;
      $display("[TB] FAIL scoreboard_empty: queue size 0, required >0");
      return;
    end
    p = sb.pop_front();
    got_dice = dice_roll;
    tests_run++;
    if (dice_roll !== p.dice) begin
      tests_failed++;
      $display("[TB] FAIL dice_roll: got %0d, expected %0d", dice_roll, p.dice);
    end
    tests_run++;
    if (player_turn !== p.player) begin
      tests_failed++;
      $display("[TB] FAIL player_turn: got %0b, expected %0b", player_turn, p.player);
    end
    tests_run++;
    if (got_lat !== p.lat) begin
      tests_failed++;
      $display("[TB] FAIL roll_latency: got %0d edges, expected %0d", got_lat, p.lat);
    end
    for (int s = 0; s < stall; s++) begin
      roll_ready = 1'b0;
      @(negedge clk);
      tests_run++;
      if (roll_valid !== 1'b1 || dice_roll !== p.dice || player_turn !== p.player) begin
        tests_failed++;
        $display("[TB] FAIL hold_stable: valid=%0b dice=%0d turn=%0b, expected 1/%0d/%0b",
                 roll_valid, dice_roll, player_turn, p.dice, p.player);
      end
    end
    roll_ready = 1'b1;
    game_over  = go;
    @(negedge clk);
    roll_ready = 1'b0;
    game_over  = 1'b0;
    model_player = ~model_player;
    if (model_count != 8'hFF) model_count = model_count + 8'd1;
    tests_run++;
    if (roll_valid !== 1'b0 || dice_roll !== 3'd0) begin
      tests_failed++;
      $display("[TB] FAIL post_handshake: valid=%0b dice=%0d, expected 0/0", roll_valid, dice_roll);
    end
    tests_run++;
    if (player_turn !== model_player || roll_count !== model_count) begin
      tests_failed++;
      $display("[TB] FAIL turn_count: turn=%0b count=%0d, expected %0b/%0d",
               player_turn, roll_count, model_player, model_count);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (roll_valid !== 1'b0 || player_turn !== 1'b1 || roll_count !== 8'd0 || dice_roll !== 3'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_state: valid=%0b turn=%0b count=%0d dice=%0d, expected 0/1/0/0",
               roll_valid, player_turn, roll_count, dice_roll);
    end
    reset = 1'b1;
    model_lfsr   = SEED;
    model_player = 1'b1;
    model_count  = 8'd0;
    @(negedge clk);
  endtask

  task automatic test_seed_sequence();
    logic [2:0] d;
    int         lat;
    logic [2:0] want[3];
    want[0] = 3'd1;
    want[1] = 3'd2;
    want[2] = 3'd4;
    start_game = 1'b1;
    seed_load  = 1'b1;
    seed_in    = 16'h0001;
    roll_req   = 1'b1;
    @(negedge clk);
    seed_load  = 1'b0;
    roll_req   = 1'b0;
    model_lfsr = 16'h0001;
    tests_run++;
    if (roll_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL seed_priority: roll_valid=%0b, expected 0", roll_valid);
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      run_roll(0, 1'b0, d, lat);
      tests_run++;
      if (d !== want[i] || lat !== 1) begin
        tests_failed++;
        $display("[TB] FAIL seed_roll_%0d: dice=%0d lat=%0d, expected %0d/1", i, d, lat, want[i]);
      end
    end
    tests_run++;
    if (roll_count !== 8'd3) begin
      tests_failed++;
      $display("[TB] FAIL seed_count: got %0d, expected 3", roll_count);
    end
  endtask

  task automatic test_rejection_fallback();
    logic [2:0] d;
    int         lat;
    run_roll(0, 1'b0, d, lat);
    // Three rejections plus the fallback draw: valid appears after 4 DRAW edges.
    tests_run++;
    if (d !== 3'd1 || lat !== MAX_REJ) begin
      tests_failed++;
      $display("[TB] FAIL fallback: dice=%0d lat=%0d, expected 1/%0d", d, lat, MAX_REJ);
    end
  endtask

  task automatic test_backpressure();
    logic [2:0] d;
    int         lat;
    run_roll(10, 1'b0, d, lat);
    tests_run++;
    if (roll_count !== 8'd5) begin
      tests_failed++;
      $display("[TB] FAIL backpressure_count: got %0d, expected 5", roll_count);
    end
  endtask

  task automatic test_game_over();
    logic [2:0] d;
    int         lat;
    int         seen;
    run_roll(0, 1'b1, d, lat);
    roll_req = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (roll_valid) seen++;
    end
    roll_req = 1'b0;
    tests_run++;
    if (seen !== 0) begin
      tests_failed++;
      $display("[TB] FAIL done_ignores_req: valid seen %0d cycles, expected 0", seen);
    end
    start_game = 1'b0;
    repeat (2) @(negedge clk);
    start_game = 1'b1;
    tests_run++;
    if (player_turn !== 1'b1 || roll_count !== 8'd6) begin
      tests_failed++;
      $display("[TB] FAIL done_retain: turn=%0b count=%0d, expected 1/6", player_turn, roll_count);
    end
  endtask

  task automatic test_zero_seed_and_reset();
    logic [2:0] d;
    int         lat;
    seed_load = 1'b1;
    seed_in   = 16'h0000;
    @(negedge clk);
    seed_load  = 1'b0;
    model_lfsr = SEED;
    run_roll(0, 1'b0, d, lat);
    tests_run++;
    if (d !== 3'd1) begin
      tests_failed++;
      $display("[TB] FAIL zero_seed_roll: dice=%0d, expected 1", d);
    end
    roll_req = 1'b1;
    @(negedge clk);
    roll_req = 1'b0;
    reset    = 1'b0;
    #1;
    tests_run++;
    if (roll_valid !== 1'b0 || dice_roll !== 3'd0 || player_turn !== 1'b1 || roll_count !== 8'd0) begin
      tests_failed++;
      $display("[TB] FAIL async_reset: valid=%0b dice=%0d turn=%0b count=%0d, expected 0/0/1/0",
               roll_valid, dice_roll, player_turn, roll_count);
    end
    @(negedge clk);
    reset        = 1'b1;
    model_lfsr   = SEED;
    model_player = 1'b1;
    model_count  = 8'd0;
    @(negedge clk);
    run_roll(0, 1'b0, d, lat);
    tests_run++;
    if (d !== 3'd1 || roll_count !== 8'd1) begin
      tests_failed++;
      $display("[TB] FAIL reset_reseed: dice=%0d count=%0d, expected 1/1", d, roll_count);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b0;
    start_game   = 1'b0;
    seed_load    = 1'b0;
    seed_in      = 16'h0000;
    roll_req     = 1'b0;
    game_over    = 1'b0;
    roll_ready   = 1'b0;
    model_lfsr   = SEED;
    model_player = 1'b1;
    model_count  = 8'd0;
    test_reset();
    test_seed_sequence();
    test_rejection_fallback();
    test_backpressure();
    test_game_over();
    test_zero_seed_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
